// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment bits are ordered GFEDCBA, active high.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_e;

  typedef struct packed {
    logic       dp;
    logic [3:0] nib;
  } digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment glyph decoder.
// Shared with the single-digit counter display.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with shadow/active banks,
// frame-boundary commit, blank gap and leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          lzb,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  input  logic                          wr_dp,
  output logic [6:0]                    seg_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic                          frame_tick
);

  localparam int AW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] BL_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DW_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_DIGITS - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  commit_d;
  logic                  ft_q;
  logic                  rdy_q;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  digit_t sh_q  [NUM_DIGITS];
  digit_t act_q [NUM_DIGITS];

  logic                  wr_fire;
  logic [NUM_DIGITS-1:0] lz_m;
  logic                  zero_run;
  logic [6:0]            seg_dec;

  // Phase sequencing: IDLE -> BLANK -> DRIVE per digit, en=0 aborts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BL_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Next cycle is the last dwell cycle of the last digit.
  always_comb begin
    commit_d = (state_d == ST_DRIVE) &&
               (idx_d == IDX_LAST) &&
               (cnt_d == DW_LAST);
  end

  // State, index and phase counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ft_q    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ft_q    <= commit_d;
      rdy_q   <= ~commit_d;
    end
  end

  assign wr_fire = wr_valid && rdy_q &&
                   ({1'b0, wr_addr} < (AW + 1)'(NUM_DIGITS));

  // Shadow bank takes host writes; active bank tracks it in IDLE
  // and at each commit so a frame never shows a half-written value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_fire && wr_addr == AW'(i)) begin
          sh_q[i] <= '{dp: wr_dp, nib: wr_data};
        end
        if (state_q == ST_IDLE || ft_q) begin
          act_q[i] <= sh_q[i];
        end
      end
    end
  end

  // Digit i is a leading zero when it and every higher digit are 0.
  always_comb begin
    zero_run = 1'b1;
    lz_m     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (act_q[i].nib == 4'h0);
      lz_m[i]  = zero_run && (i > 0);
    end
  end

  seg7_hex_decode u_dec (
    .nib_i (act_q[idx_d].nib),
    .seg_o (seg_dec)
  );

  // Output drive for the cycle being entered.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    dig_d = '0;
    if (state_d == ST_DRIVE) begin
      dig_d[idx_d] = 1'b1;
      dp_d         = act_q[idx_d].dp;
      seg_d        = (lzb && lz_m[idx_d]) ? SEG_BLANK : seg_dec;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b0;
      dig_q <= '0;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      dig_q <= dig_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_sel    = dig_q;
  assign frame_tick = ft_q;
  assign wr_ready   = rdy_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-cathode 7-segment digits sharing one segment bus. Host writes hex nibbles and decimal points into a shadow register bank through a valid/ready port. The controller commits the shadow bank atomically at frame boundaries, then scans the digits with a programmable dwell time and an anti-ghosting blank gap. It sits between the counter/datapath logic and the `uo_out` pins.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of multiplexed digits (2..8).
- `DWELL_CYCLES`, 1000: clk cycles each digit is driven (>=1).
- `BLANK_CYCLES`, 16: clk cycles all digits are off before each digit (>=1).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  scan enable; 0 forces all outputs off.
- `lzb`  in  1  leading-zero blanking enable.
- `wr_valid`  in  1  host write request.
- `wr_ready`  out  1  write accepted when `wr_valid` and `wr_ready` are both high.
- `wr_addr`  in  $clog2(NUM_DIGITS)  digit index; 0 is the least significant digit.
- `wr_data`  in  4  hex value 0x0..0xF.
- `wr_dp`  in  1  decimal point for that digit.
- `seg_out`  out  7  segments GFEDCBA, active high.
- `dp_out`  out  1  decimal point, active high.
- `dig_sel`  out  NUM_DIGITS  one-hot digit enable, active high.
- `frame_tick`  out  1  one-cycle pulse at the end of each frame.

## Operation
- **Registers**
  - Shadow bank `sh[i]` holds {dp, nibble}; the host writes it.
  - Active bank `act[i]` is the bank that is displayed.
  - Reset clears both banks to 0.
- **State machine**
  - IDLE:
    - When `en=0`, the next state is IDLE; otherwise it is BLANK with digit index `idx=0`.
    - In IDLE, `act` copies `sh` every cycle.
  - BLANK:
    - Runs `BLANK_CYCLES` cycles, then goes to DRIVE.
  - DRIVE:
    - Runs `DWELL_CYCLES` cycles.
    - When `idx<NUM_DIGITS-1`: `idx++`, then BLANK.
    - When `idx=NUM_DIGITS-1`: `idx=0`, then BLANK. The last DRIVE cycle of this digit is the commit cycle.
  - `en=0` in any state: the next state is IDLE, `idx=0`, and the phase counter clears.
- **Commit cycle**
  - `act<=sh` (all digits at once).
  - `frame_tick=1`.
  - `wr_ready=0`.
- **Write port**
  - `wr_ready=1` in every cycle except the commit cycle.
  - An accepted write updates `sh[wr_addr]` on the same edge.
  - A write to an out-of-range address is accepted and dropped.
  - A write held in the commit cycle is not lost: the host keeps `wr_valid` asserted and it is accepted on the next cycle.
- **Decode**
  - Standard hex glyphs: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- **Leading-zero blanking**
  - Applies only when `lzb=1`.
  - Digit i is blanked (`seg_out=0`) if `act[j].nibble==0` for all j>=i and i>0.
  - Digit 0 is never blanked.
  - `dp_out` still follows `act[i].dp` on blanked digits.
- **Outputs**
  - `dig_sel`, `seg_out` and `dp_out` are nonzero only in DRIVE.
  - In IDLE and BLANK all three outputs are 0.

## Timing
- Reset values:
  - `seg_out=0`, `dp_out=0`, `dig_sel=0`, `frame_tick=0`, `wr_ready=1`.
  - State is IDLE and `idx=0`.
- All outputs are registered and update on the same edge as the state.
- `en` rising:
  - First BLANK cycle on the next edge.
  - First DRIVE of digit 0 comes `BLANK_CYCLES` cycles later.
- Frame length is exactly `NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES)` cycles; `frame_tick` period equals the frame length.
- Write-to-display latency (when `en=1`): the host's value appears on `seg_out` in the frame after the next commit.
- `en` falling: outputs are 0 from the next edge, regardless of the current phase.
- Asynchronous reset mid-frame: all outputs clear immediately, and the banks clear.

## Structure
- `seg7_pkg` holds:
  - the state enum (IDLE/BLANK/DRIVE);
  - the 16-entry segment constant table;
  - the `SEG_BLANK` constant.
- Sub-module `seg7_hex_decode`: combinational nibble to 7-segment decoder, reused by the existing single-digit counter.
- Top level: FSM, phase counter, `idx`, shadow/active banks, and LZB logic.

## Test plan
(Parameters for all tests: `NUM_DIGITS=4`, `DWELL_CYCLES=4`, `BLANK_CYCLES=2`.)
- **Reset.** Assert `rst_n=0`, release it with `en=0`.
  - Required: all outputs 0, `wr_ready=1`.
  - Set `en=1`: `dig_sel` sequence is 0,0,0001x4,0,0,0010x4, …; `frame_tick` pulses every 24 cycles.
- **Write/commit.** With `en=1`, write `sh[2]=0x5` mid-frame.
  - Required: digit 2 shows 0x3F until the commit cycle, then 0x6D from the next frame.
  - `wr_ready=0` only in the commit cycle.
- **Commit collision.** Hold `wr_valid` across the commit cycle.
  - Required: the write is accepted one cycle later and appears one frame later.
- **LZB.** Set digits {0,0,4,0} (MSB first) with `lzb=1`.
  - Required: digits 3 and 2 have `seg_out=0`, digit 1 shows 0x66, digit 0 shows 0x3F.
  - With `lzb=0`: digits 3 and 2 show 0x3F.
- **Enable drop.** Drop `en` during DRIVE of digit 1.
  - Required: outputs are 0 on the next edge.
  - Re-enable: the scan restarts at digit 0 after 2 blank cycles.
- **Async reset.** Assert `rst_n` low mid-DRIVE.
  - Required: `dig_sel=0` immediately.
  - After release, all digits show 0x3F once enabled.
